alu_seq16: RTL
==============

ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 SHALL have parameter OP_ADD, default 4'b0000, ALU opcode for add-with-carry (in1 + in2 + carry_in).
REQ-002 SHALL have parameter OP_SUB, default 4'b0001, ALU opcode for subtract (in1 + ~in2 + carry_in).
REQ-003 SHALL have parameter OP_SHL, default 4'b0010, ALU opcode for shift-left-by-1 (carry_in into bit0, bit7 to carry_out).
REQ-004 SHALL have parameter OP_SHR, default 4'b1010, ALU opcode for shift-right-by-1 (carry_in into bit7, bit0 to carry_out).
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  2  00 ADD16, 01 SUB16, 10 SHL16, 11 SHR16.
- req_a  in  16  operand A.
- req_b  in  16  operand B (ignored for shifts).
- resp_valid  out  1  result present.
- resp_ready  in  1  result consumed when high with resp_valid.
- resp_data  out  16  result.
- resp_carry  out  1  final carry out (SUB: 1 = no borrow).
- resp_zero  out  1  resp_data == 0 (see Configuration).
- alu_en  out  1  ALU pass active this cycle.
- alu_in1, alu_in2  out  8 each  ALU operands.
- alu_opcode  out  4  ALU operation.
- alu_carry_in  out  1  ALU carry in.
- alu_result  in  8  combinational ALU result.
- alu_carry_out  in  1  combinational ALU carry out.

Function
REQ-006 SHALL implement FSM IDLE -> PASS0 -> PASS1 -> RESP -> IDLE.
REQ-007 req_ready SHALL be high only in IDLE; handshake in IDLE latches req_op/req_a/req_b and moves to PASS0.
REQ-008 PASS0 SHALL drive alu_en=1; ADD/SUB/SHL: low bytes; SHR: high bytes; result byte and alu_carry_out registered at end of cycle.
REQ-009 PASS0 alu_carry_in SHALL be 0 for ADD, SHL, SHR and 1 for SUB.
REQ-010 PASS1 SHALL drive the remaining byte with alu_carry_in = carry registered in PASS0; result byte and carry registered at end of cycle.
REQ-011 Shifts SHALL drive alu_in2 = 8'h00.
REQ-012 In IDLE and RESP, alu_en, alu_in1, alu_in2, alu_opcode and alu_carry_in SHALL be 0.
REQ-013 RESP SHALL hold resp_valid=1 and stable resp_data/resp_carry/resp_zero until resp_ready; then IDLE next cycle.
REQ-014 Latency: accept edge to resp_valid high = 3 cycles; with resp_ready tied high, one op per 4 cycles.
REQ-015 req_valid in PASS0/PASS1/RESP SHALL be ignored (no acceptance, no state change).
REQ-016 resp_valid SHALL be 0 in all states except RESP.

Reset
REQ-017 reset SHALL, at the next rising edge, force IDLE, resp_valid=0, resp_data=0, resp_carry=0, resp_zero=0, all alu_* outputs 0, req_ready=1.
REQ-018 reset during PASS0/PASS1/RESP SHALL abort the operation with no response issued; reset has priority over any handshake in the same cycle.

Configuration
REQ-019 With ALU_SEQ16_FLAGS_EN defined, resp_zero SHALL be registered high in RESP iff resp_data == 16'h0000.
REQ-020 Without ALU_SEQ16_FLAGS_EN, resp_zero SHALL be constant 0 and no zero-detect logic instantiated; all else unchanged.

Verification
REQ-021 ADD16 A=0x12FF B=0x0001 -> resp_data=0x1300, resp_carry=0, PASS1 alu_carry_in=1, resp_valid 3 cycles after accept.
REQ-022 SUB16 A=0x0000 B=0x0001 -> resp_data=0xFFFF, resp_carry=0; SUB16 A=0x0005 B=0x0005 -> 0x0000, carry=1, resp_zero=1 (macro defined).
REQ-023 SHL16 A=0x8081 -> resp_data=0x0102, resp_carry=1; SHR16 A=0x0101 -> resp_data=0x0080, resp_carry=1, PASS0 alu_in1=0x01 (high byte).
REQ-024 resp_ready low 5 cycles in RESP, req_valid held high -> resp_data stable, req_ready=0 throughout, next op accepted exactly one cycle after resp handshake.
REQ-025 reset asserted in PASS1 -> next cycle IDLE, req_ready=1, resp_valid never asserted for aborted op.

Source files
------------

// File: rtl/alu_seq16.sv
// -----------------------------------------------------------------------------
// alu_seq16
//
// Purpose:
//   16-bit sequencer that performs ADD16 / SUB16 / SHL16 / SHR16 by driving an
//   external combinational 8-bit ALU for two consecutive byte passes. The
//   carry out of the first pass is chained into the second pass, so the
//   16-bit carry/borrow and shift-through bits fall out naturally.
//
//   FSM: IDLE -> PASS0 -> PASS1 -> RESP -> IDLE
//     IDLE : req_ready=1; a request handshake latches op/operands.
//     PASS0: first byte (low byte, or high byte for SHR).
//     PASS1: remaining byte, carry_in = carry captured at end of PASS0.
//     RESP : result held until resp_ready.
//
//   All ALU-side outputs are registered. They are loaded one cycle ahead
//   (on the accept edge for PASS0, on the PASS0 edge for PASS1) so that they
//   are valid for the whole pass cycle and cleared again on entry to RESP.
//
// Configuration:
//   ALU_SEQ16_FLAGS_EN - when defined, resp_zero is a registered zero flag of
//   the response data. When undefined, resp_zero is tied to 0 and no
//   zero-detect logic exists.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   req_valid      in   request present
//   req_ready      out  request accepted when high together with req_valid
//   req_op[1:0]    in   00 ADD16, 01 SUB16, 10 SHL16, 11 SHR16
//   req_a[15:0]    in   operand A
//   req_b[15:0]    in   operand B (ignored for shifts)
//   resp_valid     out  result present
//   resp_ready     in   result consumed when high together with resp_valid
//   resp_data[15:0]out  result
//   resp_carry     out  final carry out (SUB: 1 = no borrow)
//   resp_zero      out  resp_data == 0 (flag build only, else 0)
//   alu_en         out  ALU pass active this cycle
//   alu_in1[7:0]   out  ALU operand 1
//   alu_in2[7:0]   out  ALU operand 2
//   alu_opcode[3:0]out  ALU operation
//   alu_carry_in   out  ALU carry in
//   alu_result[7:0]in   combinational ALU result
//   alu_carry_out  in   combinational ALU carry out
// -----------------------------------------------------------------------------
module alu_seq16 #(
  parameter logic [3:0] OP_ADD = 4'b0000,
  parameter logic [3:0] OP_SUB = 4'b0001,
  parameter logic [3:0] OP_SHL = 4'b0010,
  parameter logic [3:0] OP_SHR = 4'b1010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_carry,
  output logic        resp_zero,
  output logic        alu_en,
  output logic [7:0]  alu_in1,
  output logic [7:0]  alu_in2,
  output logic [3:0]  alu_opcode,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry_out
);

  // Request-side operation encoding
  localparam logic [1:0] REQ_ADD = 2'b00;
  localparam logic [1:0] REQ_SUB = 2'b01;
  localparam logic [1:0] REQ_SHL = 2'b10;
  localparam logic [1:0] REQ_SHR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS0 = 2'd1,
    S_PASS1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;

  // Latched request
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [7:0]  r_b_hi;      // low byte of B is consumed on the accept edge

  // Registered outputs
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [15:0] r_resp_data;
  logic        r_resp_carry;
  logic        r_alu_en;
  logic [7:0]  r_alu_in1;
  logic [7:0]  r_alu_in2;
  logic [3:0]  r_alu_opcode;
  logic        r_alu_carry_in;

  // First-pass setup derived from the live request
  logic        w_req_shift;
  logic        w_req_shr;
  logic [3:0]  w_req_opcode;
  logic [7:0]  w_req_in1;
  logic [7:0]  w_req_in2;

  // Second-pass setup derived from the latched request
  logic        w_lat_shift;
  logic        w_lat_shr;
  logic [7:0]  w_lat_in1;
  logic [7:0]  w_lat_in2;

  // Full 16-bit result as it will look after the PASS1 byte is merged in
  logic [15:0] w_data_after_pass1;

  always_comb begin
    w_req_opcode = OP_ADD;
    case (req_op)
      REQ_ADD: w_req_opcode = OP_ADD;
      REQ_SUB: w_req_opcode = OP_SUB;
      REQ_SHL: w_req_opcode = OP_SHL;
      REQ_SHR: w_req_opcode = OP_SHR;
      default: w_req_opcode = OP_ADD;
    endcase
  end

  assign w_req_shift = (req_op == REQ_SHL) || (req_op == REQ_SHR);
  assign w_req_shr   = (req_op == REQ_SHR);
  // SHR walks from the high byte down so the bit shifted out of the high
  // byte becomes the carry into bit 7 of the low byte.
  assign w_req_in1   = w_req_shr   ? req_a[15:8] : req_a[7:0];
  assign w_req_in2   = w_req_shift ? 8'h00       : req_b[7:0];

  assign w_lat_shift = (r_op == REQ_SHL) || (r_op == REQ_SHR);
  assign w_lat_shr   = (r_op == REQ_SHR);
  assign w_lat_in1   = w_lat_shr   ? r_a[7:0] : r_a[15:8];
  assign w_lat_in2   = w_lat_shift ? 8'h00    : r_b_hi;

  assign w_data_after_pass1 = w_lat_shr ? {r_resp_data[15:8], alu_result}
                                        : {alu_result, r_resp_data[7:0]};

  // Main FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= REQ_ADD;
      r_a            <= 16'h0000;
      r_b_hi         <= 8'h00;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= 16'h0000;
      r_resp_carry   <= 1'b0;
      r_alu_en       <= 1'b0;
      r_alu_in1      <= 8'h00;
      r_alu_in2      <= 8'h00;
      r_alu_opcode   <= 4'h0;
      r_alu_carry_in <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state        <= S_PASS0;
            r_req_ready    <= 1'b0;
            r_op           <= req_op;
            r_a            <= req_a;
            r_b_hi         <= req_b[15:8];
            // Present the first pass to the ALU for the PASS0 cycle
            r_alu_en       <= 1'b1;
            r_alu_opcode   <= w_req_opcode;
            r_alu_in1      <= w_req_in1;
            r_alu_in2      <= w_req_in2;
            r_alu_carry_in <= (req_op == REQ_SUB);
          end
        end

        S_PASS0: begin
          if (w_lat_shr) begin
            r_resp_data[15:8] <= alu_result;
          end else begin
            r_resp_data[7:0]  <= alu_result;
          end
          // Present the second pass, chaining the first-pass carry
          r_alu_in1      <= w_lat_in1;
          r_alu_in2      <= w_lat_in2;
          r_alu_carry_in <= alu_carry_out;
          r_state        <= S_PASS1;
        end

        S_PASS1: begin
          r_resp_data    <= w_data_after_pass1;
          r_resp_carry   <= alu_carry_out;
          r_resp_valid   <= 1'b1;
          r_alu_en       <= 1'b0;
          r_alu_opcode   <= 4'h0;
          r_alu_in1      <= 8'h00;
          r_alu_in2      <= 8'h00;
          r_alu_carry_in <= 1'b0;
          r_state        <= S_RESP;
        end

        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ16_FLAGS_EN
  // Zero flag is computed from the merged result so it is valid in RESP
  // together with resp_data.
  logic r_resp_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_zero <= 1'b0;
    end else if (r_state == S_PASS1) begin
      r_resp_zero <= (w_data_after_pass1 == 16'h0000);
    end
  end

  assign resp_zero = r_resp_zero;
`else
  assign resp_zero = 1'b0;
`endif

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_carry   = r_resp_carry;
  assign alu_en       = r_alu_en;
  assign alu_in1      = r_alu_in1;
  assign alu_in2      = r_alu_in2;
  assign alu_opcode   = r_alu_opcode;
  assign alu_carry_in = r_alu_carry_in;

endmodule
